// File: rtl/regfile_bypass_pkg.sv
// Shared definitions for the register file with operand forwarding.
// Holds the layout of the write (RFW) bus and the reset value of the registers.
// Every file of the block imports this package.
package regfile_bypass_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int RFW_W  = 39;

  // Bit positions within a write bus
  localparam int RFWE    = 38;  // write enable
  localparam int RFWC    = 37;  // data ready (low: load still in flight)
  localparam int RFWA_HI = 36;
  localparam int RFWA_LO = 32;
  localparam int RFWD_HI = 31;
  localparam int RFWD_LO = 0;

  localparam logic [DATA_W-1:0] DATA_INITIAL = '0;

  typedef struct packed {
    logic              we;
    logic              rdy;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rfw_t;

  // Split a raw write bus into its named fields
  function automatic rfw_t rfw_decode(input logic [RFW_W-1:0] bus);
    rfw_t f;
    f.we   = bus[RFWE];
    f.rdy  = bus[RFWC];
    f.addr = bus[RFWA_HI:RFWA_LO];
    f.data = bus[RFWD_HI:RFWD_LO];
    return f;
  endfunction

endpackage

// File: rtl/regfile_bypass_fwd_mux.sv
// Operand selector: picks the youngest matching producer, otherwise the regfile value.
// Latency: purely combinational.
// Backpressure: raises not_ready when the winning execute-stage producer has no data yet.
module fwd_mux
  import regfile_bypass_pkg::*;
(
  input  logic [ADDR_W-1:0] rs,
  input  logic              rs_v,
  input  logic [RFW_W-1:0]  s1_0,
  input  logic              s1_num0,
  input  logic [RFW_W-1:0]  s1_1,
  input  logic              s1_num1,
  input  logic [RFW_W-1:0]  m_0,
  input  logic              num0,
  input  logic [RFW_W-1:0]  m_1,
  input  logic              num1,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] data,
  output logic              not_ready
);

  rfw_t e_first, e_second, m_first, m_second;
  logic unused_mem_rdy;

  // Order each stage's two lanes youngest first; on equal tags lane 1 counts as younger
  always_comb begin
    e_first  = rfw_decode(s1_1);
    e_second = rfw_decode(s1_0);
    m_first  = rfw_decode(m_1);
    m_second = rfw_decode(m_0);
    if (s1_num0 && !s1_num1) begin
      e_first  = rfw_decode(s1_0);
      e_second = rfw_decode(s1_1);
    end
    if (num0 && !num1) begin
      m_first  = rfw_decode(m_0);
      m_second = rfw_decode(m_1);
    end
  end

  // Memory-stage results are always complete, so their ready bit is not consulted
  assign unused_mem_rdy = m_first.rdy ^ m_second.rdy;

  // Priority select; a not-ready winner stalls rather than falling through to older data
  always_comb begin
    data      = '0;
    not_ready = 1'b0;
    if (!rs_v || rs == '0) begin
      data = '0;
    end else if (e_first.we && e_first.addr == rs) begin
      if (e_first.rdy) data = e_first.data;
      else             not_ready = 1'b1;
    end else if (e_second.we && e_second.addr == rs) begin
      if (e_second.rdy) data = e_second.data;
      else              not_ready = 1'b1;
    end else if (m_first.we && m_first.addr == rs) begin
      data = m_first.data;
    end else if (m_second.we && m_second.addr == rs) begin
      data = m_second.data;
    end else begin
      data = rf_data;
    end
  end

endmodule

// File: rtl/regfile_bypass.sv
// Dual-lane register file (x0 hardwired to zero) with execute/memory-stage forwarding.
// Latency: zero-cycle reads; writes land at the clock edge.
// Backpressure: stop requests a load-use stall; writes still drain while stopped.
module regfile_bypass
  import regfile_bypass_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_0,
  input  logic [ADDR_W-1:0] rs2_0,
  input  logic [ADDR_W-1:0] rs1_1,
  input  logic [ADDR_W-1:0] rs2_1,
  input  logic              rs1v_0,
  input  logic              rs2v_0,
  input  logic              rs1v_1,
  input  logic              rs2v_1,
  input  logic [RFW_W-1:0]  rfw_s1_0,
  input  logic [RFW_W-1:0]  rfw_s1_1,
  input  logic              s1_num0,
  input  logic              s1_num1,
  input  logic [RFW_W-1:0]  rfw_0,
  input  logic [RFW_W-1:0]  rfw_1,
  input  logic              num0,
  input  logic              num1,
  output logic [DATA_W-1:0] rdata1_0,
  output logic [DATA_W-1:0] rdata2_0,
  output logic [DATA_W-1:0] rdata1_1,
  output logic [DATA_W-1:0] rdata2_1,
  output logic              stop,
  output logic [31:0]       stall_cnt
);

  logic [DATA_W-1:0] regs [1:NREG-1];

  rfw_t w0, w1;
  logic wr0, wr1, collide, lane0_wins, unused_w_rdy;

  assign w0           = rfw_decode(rfw_0);
  assign w1           = rfw_decode(rfw_1);
  assign unused_w_rdy = w0.rdy ^ w1.rdy;

  assign wr0        = w0.we && w0.addr != '0 && int'(w0.addr) < NREG;
  assign wr1        = w1.we && w1.addr != '0 && int'(w1.addr) < NREG;
  assign collide    = wr0 && wr1 && w0.addr == w1.addr;
  assign lane0_wins = num0 && !num1;

  // Register file update; on a same-address collision only the younger lane lands
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) regs[i] <= DATA_INITIAL;
    end else begin
      if (wr0 && !(collide && !lane0_wins)) regs[w0.addr] <= w0.data;
      if (wr1 && !(collide && lane0_wins))  regs[w1.addr] <= w1.data;
    end
  end

  function automatic logic [DATA_W-1:0] rf_read(input logic [ADDR_W-1:0] a);
    rf_read = DATA_INITIAL;
    if (a != '0 && int'(a) < NREG) rf_read = regs[a];
  endfunction

  logic [ADDR_W-1:0] rs_a   [4];
  logic              rsv_a  [4];
  logic [DATA_W-1:0] data_a [4];
  logic              nrdy_a [4];

  assign rs_a[0] = rs1_0;  assign rsv_a[0] = rs1v_0;
  assign rs_a[1] = rs2_0;  assign rsv_a[1] = rs2v_0;
  assign rs_a[2] = rs1_1;  assign rsv_a[2] = rs1v_1;
  assign rs_a[3] = rs2_1;  assign rsv_a[3] = rs2v_1;

  for (genvar k = 0; k < 4; k++) begin : g_port
    fwd_mux u_fwd (
      .rs        (rs_a[k]),
      .rs_v      (rsv_a[k]),
      .s1_0      (rfw_s1_0),
      .s1_num0   (s1_num0),
      .s1_1      (rfw_s1_1),
      .s1_num1   (s1_num1),
      .m_0       (rfw_0),
      .num0      (num0),
      .m_1       (rfw_1),
      .num1      (num1),
      .rf_data   (rf_read(rs_a[k])),
      .data      (data_a[k]),
      .not_ready (nrdy_a[k])
    );
  end

  assign rdata1_0 = data_a[0];
  assign rdata2_0 = data_a[1];
  assign rdata1_1 = data_a[2];
  assign rdata2_1 = data_a[3];
  assign stop     = nrdy_a[0] | nrdy_a[1] | nrdy_a[2] | nrdy_a[3];

  // Stall cycle counter, free-running wrap
  always_ff @(posedge clk) begin
    if (rst)       stall_cnt <= '0;
    else if (stop) stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_regfile_bypass.sv
// Randomized bench with a behavioural register/forwarding model and per-cycle compare,
// plus directed scenarios with hand-computed literal expectations.
module tb_regfile_bypass;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_0, rs2_0, rs1_1, rs2_1;
  logic        rs1v_0, rs2v_0, rs1v_1, rs2v_1;
  logic [38:0] rfw_s1_0, rfw_s1_1, rfw_0, rfw_1;
  logic        s1_num0, s1_num1, num0, num1;
  logic [31:0] rdata1_0, rdata2_0, rdata1_1, rdata2_1;
  logic        stop;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [31:0] mrf [32];
  logic [31:0] mcnt;

  always #5 clk = ~clk;

  regfile_bypass #(.NREG(32)) dut (
    .clk(clk), .rst(rst),
    .rs1_0(rs1_0), .rs2_0(rs2_0), .rs1_1(rs1_1), .rs2_1(rs2_1),
    .rs1v_0(rs1v_0), .rs2v_0(rs2v_0), .rs1v_1(rs1v_1), .rs2v_1(rs2v_1),
    .rfw_s1_0(rfw_s1_0), .rfw_s1_1(rfw_s1_1), .s1_num0(s1_num0), .s1_num1(s1_num1),
    .rfw_0(rfw_0), .rfw_1(rfw_1), .num0(num0), .num1(num1),
    .rdata1_0(rdata1_0), .rdata2_0(rdata2_0), .rdata1_1(rdata1_1), .rdata2_1(rdata2_1),
    .stop(stop), .stall_cnt(stall_cnt)
  );

  function automatic logic [38:0] mk(input bit we, input bit rdy, input int addr, input logic [31:0] d);
    logic [4:0] a;
    a = addr[4:0];
    return {we, rdy, a, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: scan producers youngest to oldest by program-order tag, then the register array.
  function automatic void model_op(input logic [4:0] rs, input logic v,
                                   output logic [31:0] d, output bit nr);
    logic [38:0] prod [4];
    bit          is_exec [4];
    d  = 32'h0;
    nr = 1'b0;
    if (!v || rs == 5'd0) return;
    prod[0] = (s1_num0 && !s1_num1) ? rfw_s1_0 : rfw_s1_1;
    prod[1] = (s1_num0 && !s1_num1) ? rfw_s1_1 : rfw_s1_0;
    prod[2] = (num0 && !num1) ? rfw_0 : rfw_1;
    prod[3] = (num0 && !num1) ? rfw_1 : rfw_0;
    is_exec = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      if (prod[i][38] && prod[i][36:32] == rs) begin
        if (is_exec[i] && !prod[i][37]) nr = 1'b1;
        else d = prod[i][31:0];
        return;
      end
    end
    d = mrf[rs];
  endfunction

  function automatic bit model_stop();
    logic [31:0] d;
    bit nr, any;
    any = 1'b0;
    model_op(rs1_0, rs1v_0, d, nr); any |= nr;
    model_op(rs2_0, rs2v_0, d, nr); any |= nr;
    model_op(rs1_1, rs1v_1, d, nr); any |= nr;
    model_op(rs2_1, rs2v_1, d, nr); any |= nr;
    return any;
  endfunction

  // Model state update at the clock edge: older write first, younger write overwrites
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
      mcnt = 32'h0;
    end else begin
      if (model_stop()) mcnt = mcnt + 32'd1;
      if (num0 && !num1) begin
        if (rfw_1[38]) mrf[rfw_1[36:32]] = rfw_1[31:0];
        if (rfw_0[38]) mrf[rfw_0[36:32]] = rfw_0[31:0];
      end else begin
        if (rfw_0[38]) mrf[rfw_0[36:32]] = rfw_0[31:0];
        if (rfw_1[38]) mrf[rfw_1[36:32]] = rfw_1[31:0];
      end
      mrf[0] = 32'h0;
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    logic [31:0] d;
    bit nr;
    if (chk_en) begin
      model_op(rs1_0, rs1v_0, d, nr); if (!nr) chk("cmp_rdata1_0", rdata1_0, d);
      model_op(rs2_0, rs2v_0, d, nr); if (!nr) chk("cmp_rdata2_0", rdata2_0, d);
      model_op(rs1_1, rs1v_1, d, nr); if (!nr) chk("cmp_rdata1_1", rdata1_1, d);
      model_op(rs2_1, rs2v_1, d, nr); if (!nr) chk("cmp_rdata2_1", rdata2_1, d);
      chk("cmp_stop", {31'h0, stop}, {31'h0, model_stop()});
      chk("cmp_stall_cnt", stall_cnt, mcnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rfw_s1_0 = '0; rfw_s1_1 = '0; rfw_0 = '0; rfw_1 = '0;
    s1_num0 = 0; s1_num1 = 0; num0 = 0; num1 = 0;
    rs1_0 = 0; rs2_0 = 0; rs1_1 = 0; rs2_1 = 0;
    rs1v_0 = 0; rs2v_0 = 0; rs1v_1 = 0; rs2v_1 = 0;
  endtask

  initial begin
    logic [31:0] md;
    bit mnr;
    rst = 1'b1;
    idle();
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_stall_cnt", stall_cnt, 32'h0);
    chk("reset_stop", {31'h0, stop}, 32'h0);

    // Plain write then read back
    step(); rfw_0 = mk(1, 1, 5, 32'h1234);
    step(); idle(); rs1_0 = 5; rs1v_0 = 1;
    @(negedge clk);
    chk("rd_x5", rdata1_0, 32'h1234);
    chk("rd_x5_stop", {31'h0, stop}, 32'h0);
    model_op(5'd5, 1'b1, md, mnr);
    chk("model_x5", md, 32'h1234);

    // Same-address collisions: tag 1 wins, equal tags give lane 1
    step();
    rfw_0 = mk(1, 1, 7, 32'h11); num0 = 0;
    rfw_1 = mk(1, 1, 7, 32'h22); num1 = 1;
    step(); idle();
    rfw_0 = mk(1, 1, 8, 32'h33); num0 = 1;
    rfw_1 = mk(1, 1, 8, 32'h44); num1 = 1;
    step(); idle();
    rfw_0 = mk(1, 1, 10, 32'h55); num0 = 1;
    rfw_1 = mk(1, 1, 10, 32'h66); num1 = 0;
    step(); idle();
    rs1_0 = 7; rs1v_0 = 1; rs2_0 = 8; rs2v_0 = 1; rs1_1 = 10; rs1v_1 = 1;
    @(negedge clk);
    chk("coll_x7", rdata1_0, 32'h22);
    chk("coll_tie_x8", rdata2_0, 32'h44);
    chk("coll_lane0_x10", rdata1_1, 32'h55);
    model_op(5'd7, 1'b1, md, mnr);
    chk("model_x7", md, 32'h22);

    // Execute stage beats memory stage in the same cycle
    step(); idle();
    rfw_s1_1 = mk(1, 1, 3, 32'hAA); s1_num1 = 1;
    rfw_0 = mk(1, 1, 3, 32'hBB);
    rs2_1 = 3; rs2v_1 = 1;
    @(negedge clk);
    chk("fwd_exec_x3", rdata2_1, 32'hAA);
    step(); idle(); rs2_1 = 3; rs2v_1 = 1;
    @(negedge clk);
    chk("rf_x3_after", rdata2_1, 32'hBB);

    // Exec lane with tag 1 outranks the other exec lane; invalid source reads zero
    step(); idle();
    rfw_s1_0 = mk(1, 1, 4, 32'h100); s1_num0 = 1;
    rfw_s1_1 = mk(1, 1, 4, 32'h200); s1_num1 = 0;
    rs1_1 = 4; rs1v_1 = 1; rs1_0 = 4; rs1v_0 = 0;
    @(negedge clk);
    chk("exec_prio", rdata1_1, 32'h100);
    chk("invalid_src", rdata1_0, 32'h0);

    // Load-use stall for two cycles
    step(); idle();
    rfw_s1_0 = mk(1, 0, 9, 32'h0); rs2_1 = 9; rs2v_1 = 1;
    @(negedge clk);
    chk("stall_c1_stop", {31'h0, stop}, 32'h1);
    chk("stall_c1_cnt", stall_cnt, 32'h0);
    step();
    @(negedge clk);
    chk("stall_c2_stop", {31'h0, stop}, 32'h1);
    chk("stall_c2_cnt", stall_cnt, 32'h1);
    step(); idle(); rs2_1 = 9; rs2v_1 = 1;
    @(negedge clk);
    chk("stall_end_stop", {31'h0, stop}, 32'h0);
    chk("stall_end_cnt", stall_cnt, 32'h2);

    // x0 is never written and never forwarded
    step(); idle();
    rfw_1 = mk(1, 1, 0, 32'hFFFF);
    rfw_s1_0 = mk(1, 0, 0, 32'h0);
    rs1_0 = 0; rs1v_0 = 1;
    @(negedge clk);
    chk("x0_fwd", rdata1_0, 32'h0);
    chk("x0_stop", {31'h0, stop}, 32'h0);
    step(); idle(); rs1_0 = 0; rs1v_0 = 1;
    @(negedge clk);
    chk("x0_rd", rdata1_0, 32'h0);

    // Reset in the middle of a stall
    step();
    rfw_s1_1 = mk(1, 0, 12, 32'h0); rs1_0 = 12; rs1v_0 = 1;
    step(); step(); step();
    @(negedge clk);
    chk("pre_rst_cnt", stall_cnt, 32'h5);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rst_mid_cnt", stall_cnt, 32'h0);
    step(); rst = 1'b0; idle();
    rs1_0 = 5; rs1v_0 = 1; rs2_0 = 7; rs2v_0 = 1; rs1_1 = 3; rs1v_1 = 1;
    @(negedge clk);
    chk("rst_stop_low", {31'h0, stop}, 32'h0);
    chk("rst_x5", rdata1_0, 32'h0);
    chk("rst_x7", rdata2_0, 32'h0);
    chk("rst_x3", rdata1_1, 32'h0);

    // Randomized traffic on a narrow address range to provoke hits and collisions
    for (int c = 0; c < 3000; c++) begin
      step();
      rst      = ($urandom_range(63) == 0);
      rs1_0    = 5'($urandom_range(7));  rs2_0 = 5'($urandom_range(7));
      rs1_1    = 5'($urandom_range(7));  rs2_1 = 5'($urandom_range(7));
      rs1v_0   = 1'($urandom);  rs2v_0 = 1'($urandom);
      rs1v_1   = 1'($urandom);  rs2v_1 = 1'($urandom);
      rfw_s1_0 = mk($urandom_range(3) == 0, $urandom_range(7) != 0, $urandom_range(7), $urandom);
      rfw_s1_1 = mk($urandom_range(3) == 0, $urandom_range(7) != 0, $urandom_range(7), $urandom);
      rfw_0    = mk($urandom_range(1) == 0, 1'($urandom), $urandom_range(7), $urandom);
      rfw_1    = mk($urandom_range(1) == 0, 1'($urandom), $urandom_range(7), $urandom);
      s1_num0  = 1'($urandom); s1_num1 = 1'($urandom);
      num0     = 1'($urandom); num1    = 1'($urandom);
    end
    step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_bypass.md
REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-002 Port: clk  in  1  pipeline clock.
REQ-003 Port: rst  in  1  synchronous active-high reset.
REQ-004 Port: rs1_0, rs2_0, rs1_1, rs2_1  in  5 each  source register addresses, lane 0 and lane 1 of the issuing pair.
REQ-005 Port: rs1v_0, rs2v_0, rs1v_1, rs2v_1  in  1 each  source-valid flags.
REQ-006 Port: rfw_s1_0, rfw_s1_1  in  39 each  execute-stage write bus per lane: [38] we, [37] data-ready, [36:32] addr, [31:0] data.
REQ-007 Port: s1_num0, s1_num1  in  1 each  program-order tag of each execute-stage instruction; 1 means younger.
REQ-008 Port: rfw_0, rfw_1  in  39 each  memory-stage write bus per lane, same field layout as REQ-006.
REQ-009 Port: num0, num1  in  1 each  program-order tag of each memory-stage instruction.
REQ-010 Port: rdata1_0, rdata2_0, rdata1_1, rdata2_1  out  32 each  forwarded operand values.
REQ-011 Port: stop  out  1  load-use stall request to the front end and execute pipeline registers.
REQ-012 Port: stall_cnt  out  32  count of cycles with stop asserted.
REQ-013 Parameter: NREG, default 32, number of architectural registers.

Function
REQ-014 SHALL hold registers x1..x31 in flops; x0 reads 0 and is never written.
REQ-015 SHALL write rfw_k.data to rfw_k.addr at posedge clk when rfw_k.we=1 and addr!=0.
REQ-016 SHALL, when both memory-stage lanes write the same nonzero addr in one cycle, store only the lane whose num tag is 1.
REQ-017 SHALL, when both tags are equal on a same-address collision, store lane 1.
REQ-018 SHALL form each operand combinationally in a single cycle, with zero read latency.
REQ-019 SHALL select the operand source by priority, youngest producer first: (1) execute-stage lane with tag 1, (2) execute-stage lane with tag 0, (3) memory-stage lane with tag 1, (4) memory-stage lane with tag 0, (5) register file.
REQ-020 SHALL count a producer as a match only when we=1, addr==rs, rs!=0 and the source is valid.
REQ-021 SHALL forward execute-stage data only when data-ready=1.
REQ-022 SHALL assert stop combinationally when the highest-priority matching execute-stage producer has data-ready=0, i.e. a load result that is not yet available.
REQ-023 SHALL drive 0 on any operand whose valid flag is 0 or whose rs is 0.
REQ-024 SHALL NOT resolve intra-pair hazards (lane 1 reading lane 0's destination); those belong to the issue logic.
REQ-025 SHALL continue to perform register-file writes while stop=1, because the memory stage still drains.
REQ-026 SHALL increment stall_cnt by 1 on each posedge where stop=1 and rst=0, wrapping from 0xFFFFFFFF to 0.
REQ-027 SHALL ignore rs*/rsv* values while rst=1, for the purposes of stall counting.

Reset
REQ-028 On rst=1 at posedge clk, SHALL clear x1..x31 to 0 and stall_cnt to 0, and SHALL suppress any write presented in that cycle.
REQ-029 SHALL derive stop and the operand outputs from inputs and state only, so after reset they reflect cleared registers.
REQ-030 A reset asserted during a stall SHALL clear stall_cnt on that edge; stop SHALL fall as soon as the producing bus is cleared.

Structure
REQ-031 SHALL take RFW bus field positions (RFWE, RFWC, RFWA, RFWD), widths and DATA_INITIAL from the shared definitions header.
REQ-032 SHALL place operand selection in one sub-module, fwd_mux, instantiated four times: inputs are rs, rs_v, the four buses with tags, and the regfile value; outputs are data and a not-ready flag.
REQ-033 SHALL form stop as the OR of the four fwd_mux not-ready flags.

Verification
REQ-034 Test: write x5=0x1234 via rfw_0, then the next cycle read rs1_0=5 with no producers -> rdata1_0=0x1234, stop=0.
REQ-035 Test: rfw_0 and rfw_1 both write x7, num0=0/0x11, num1=1/0x22; then read x7 -> 0x22.
REQ-036 Test: rfw_s1_1 = {we=1, ready=1, addr=3, data=0xAA} and rfw_0 writes x3=0xBB -> rdata2_1=0xAA the same cycle.
REQ-037 Test: rfw_s1_0 = {we=1, ready=0, addr=9} and rs2v_1=1, rs2_1=9 for 2 cycles -> stop=1 in both cycles, stall_cnt rises 0 to 2; clearing the bus drops stop.
REQ-038 Test: write x0=0xFFFF via rfw_1 with we=1 and a producer on addr 0 -> reads of rs=0 return 0, stop=0.
REQ-039 Test: assert rst mid-stall with stall_cnt=5 -> stall_cnt=0 and all registers read 0 after the edge.
